// File: rtl/mem_load_dump_ctrl_pkg.sv
// Shared definitions for the memory load/run/dump controller: state
// encoding, memory-select codes and the width helpers used to size the
// address, register-index and run-cycle counters.
package mem_load_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_IM = 3'd1,
        ST_LOAD_DM = 3'd2,
        ST_RUN     = 3'd3,
        ST_DUMP_RF = 3'd4,
        ST_DUMP_DM = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic MEM_SEL_IM = 1'b0;
    localparam logic MEM_SEL_DM = 1'b1;

    // Byte-address width covering the larger of the two memories.
    function automatic int calc_aw(input int imem_bytes, input int dmem_bytes);
        int m;
        m = (imem_bytes > dmem_bytes) ? imem_bytes : dmem_bytes;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Register-file index width.
    function automatic int calc_rw(input int gpr_size);
        return (gpr_size > 1) ? $clog2(gpr_size) : 1;
    endfunction

    // Run-cycle counter width; the counter must be able to hold RUN_CYCLES.
    function automatic int calc_rcw(input int run_cycles);
        return (run_cycles > 1) ? $clog2(run_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_load_dump_ctrl_if.sv
// Host byte link, CPU memory port and register-file debug port of the
// load/dump controller, bundled as one interface.
//
// Handshake rule for both byte streams: a byte moves in every cycle where
// valid and ready are both high at the rising clock edge. Once the sender
// raises valid it keeps valid and data unchanged until that transfer cycle;
// ready may change freely and never depends on a future valid.
interface mem_load_dump_ctrl_if
    import mem_load_dump_ctrl_pkg::*;
#(
    parameter int AW   = calc_aw(1024, 1024),
    parameter int RW   = calc_rw(32),
    parameter int XLEN = 32
);
    // host -> controller load stream
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    // controller -> host dump stream
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    // CPU memory port (write for load, read of data memory for dump)
    logic            mem_we;
    logic            mem_sel;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic            mem_re;
    logic [7:0]      mem_rdata;
    // register-file debug read port
    logic [RW-1:0]   rf_raddr;
    logic [XLEN-1:0] rf_rdata;

    // Controller side.
    modport master (
        input  in_valid, in_data, out_ready, mem_rdata, rf_rdata,
        output in_ready, out_valid, out_data,
        output mem_we, mem_sel, mem_addr, mem_wdata, mem_re, rf_raddr
    );

    // Host, memory and register-file side.
    modport slave (
        output in_valid, in_data, out_ready, mem_rdata, rf_rdata,
        input  in_ready, out_valid, out_data,
        input  mem_we, mem_sel, mem_addr, mem_wdata, mem_re, rf_raddr
    );

endinterface

// File: rtl/mem_load_dump_ctrl_dump_byte_serializer.sv
// Splits one XLEN-bit register word into XLEN/8 bytes, least significant
// byte first. The word source must stay constant while word_valid is high
// (the register file is frozen during the dump), so the selected byte and
// valid stay stable for as long as the host stalls.
module dump_byte_serializer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            word_valid,
    input  logic [XLEN-1:0] word,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic            word_done
);
    localparam int NB = XLEN / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    logic [BW-1:0] idx;
    logic          last;

    assign last      = (idx == LAST_IDX);
    assign out_valid = word_valid;
    assign out_data  = word[{idx, 3'b000} +: 8];
    assign word_done = word_valid && out_ready && last;

    // Byte index: advances on each transfer, wraps after the top byte, and
    // parks at 0 whenever no word is being offered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (!word_valid) begin
            idx <= '0;
        end else if (out_ready) begin
            idx <= last ? '0 : idx + BW'(1);
        end
    end

endmodule

// File: rtl/mem_load_dump_ctrl.sv
// Session controller for on-FPGA regression: loads instruction then data
// memory from the host byte stream with the CPU held in reset, lets the CPU
// run for a bounded number of cycles, then streams every GPR (LSB first)
// followed by every data-memory byte back to the host.
module mem_load_dump_ctrl
    import mem_load_dump_ctrl_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024,
    parameter int GPR_SIZE   = 32,
    parameter int XLEN       = 32,
    parameter int RUN_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cpu_halt,
    output logic                 cpu_rst_n,
    output logic                 cpu_stall,
    output logic                 busy,
    output logic                 done,
    output logic                 timed_out,
    output state_t               dbg_state,
    mem_load_dump_ctrl_if.master bus
);
    localparam int AW  = calc_aw(IMEM_BYTES, DMEM_BYTES);
    localparam int RW  = calc_rw(GPR_SIZE);
    localparam int CW  = (AW > RW) ? AW : RW;
    localparam int RCW = calc_rcw(RUN_CYCLES);

    localparam logic [CW-1:0]  IM_LAST = CW'(IMEM_BYTES - 1);
    localparam logic [CW-1:0]  DM_LAST = CW'(DMEM_BYTES - 1);
    localparam logic [CW-1:0]  RF_LAST = CW'(GPR_SIZE - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RUN_CYCLES - 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;        // load address / GPR index / dump address
    logic [RCW-1:0]  rc;         // cycles spent in RUN
    logic            dm_pend;    // data-memory read issued last cycle
    logic            dm_full;    // dm_hold carries a byte the host stalled on
    logic [7:0]      dm_hold;

    // combinational controls
    logic            in_ready_c;
    logic            mem_we_c;
    logic            mem_sel_c;
    logic [AW-1:0]   mem_addr_c;
    logic [7:0]      mem_wdata_c;
    logic            mem_re_c;
    logic [RW-1:0]   rf_raddr_c;
    logic            out_valid_c;
    logic [7:0]      out_data_c;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            tmo_clr;
    logic            tmo_set;
    logic            rc_inc;
    logic            dm_issue;
    logic            ser_word_valid;
    logic            ser_valid;
    logic [7:0]      ser_data;
    logic            ser_word_done;

    dump_byte_serializer #(
        .XLEN (XLEN)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .word_valid (ser_word_valid),
        .word       (bus.rf_rdata),
        .out_ready  (bus.out_ready),
        .out_valid  (ser_valid),
        .out_data   (ser_data),
        .word_done  (ser_word_done)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and all per-state bus controls.
    always_comb begin
        next_state     = state;
        in_ready_c     = 1'b0;
        mem_we_c       = 1'b0;
        mem_sel_c      = MEM_SEL_IM;
        mem_addr_c     = '0;
        mem_wdata_c    = '0;
        mem_re_c       = 1'b0;
        rf_raddr_c     = '0;
        out_valid_c    = 1'b0;
        out_data_c     = '0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        tmo_clr        = 1'b0;
        tmo_set        = 1'b0;
        rc_inc         = 1'b0;
        dm_issue       = 1'b0;
        ser_word_valid = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state = ST_LOAD_IM;
                    cnt_clr    = 1'b1;
                    tmo_clr    = 1'b1;
                end
            end

            ST_LOAD_IM, ST_LOAD_DM: begin
                in_ready_c = 1'b1;
                mem_sel_c  = (state == ST_LOAD_DM) ? MEM_SEL_DM : MEM_SEL_IM;
                mem_addr_c = cnt[AW-1:0];
                if (bus.in_valid) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = bus.in_data;
                    if (state == ST_LOAD_IM && cnt == IM_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = ST_LOAD_DM;
                    end else if (state == ST_LOAD_DM && cnt == DM_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = ST_RUN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // A halt seen on the limit cycle still counts as a halt.
                if (cpu_halt) begin
                    next_state = ST_DUMP_RF;
                end else if (rc == RC_LAST) begin
                    next_state = ST_DUMP_RF;
                    tmo_set    = 1'b1;
                end else begin
                    rc_inc = 1'b1;
                end
            end

            ST_DUMP_RF: begin
                rf_raddr_c     = cnt[RW-1:0];
                ser_word_valid = 1'b1;
                out_valid_c    = ser_valid;
                out_data_c     = ser_data;
                if (ser_word_done) begin
                    if (cnt == RF_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = ST_DUMP_DM;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            ST_DUMP_DM: begin
                // One read in flight at most: read, then present the byte
                // straight from mem_rdata, or from dm_hold after a stall.
                out_valid_c = dm_pend || dm_full;
                out_data_c  = dm_pend ? bus.mem_rdata : dm_hold;
                if (!dm_pend && !dm_full) begin
                    mem_re_c   = 1'b1;
                    mem_sel_c  = MEM_SEL_DM;
                    mem_addr_c = cnt[AW-1:0];
                    dm_issue   = 1'b1;
                end
                if (out_valid_c && bus.out_ready) begin
                    if (cnt == DM_LAST) begin
                        cnt_clr    = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Shared byte/index counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    // RUN cycle counter, held at 0 outside RUN so each run starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc <= '0;
        end else if (state != ST_RUN) begin
            rc <= '0;
        end else if (rc_inc) begin
            rc <= rc + RCW'(1);
        end
    end

    // Timeout flag: cleared when a session starts, set on a forced stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timed_out <= 1'b0;
        end else if (tmo_clr) begin
            timed_out <= 1'b0;
        end else if (tmo_set) begin
            timed_out <= 1'b1;
        end
    end

    // Data-memory read tracking and the one-entry holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_pend <= 1'b0;
            dm_full <= 1'b0;
            dm_hold <= '0;
        end else if (state != ST_DUMP_DM) begin
            dm_pend <= 1'b0;
            dm_full <= 1'b0;
            dm_hold <= '0;
        end else begin
            if (dm_issue) begin
                dm_pend <= 1'b1;
            end
            if (dm_pend) begin
                dm_pend <= 1'b0;
                if (!bus.out_ready) begin
                    dm_full <= 1'b1;
                    dm_hold <= bus.mem_rdata;
                end
            end
            if (dm_full && bus.out_ready) begin
                dm_full <= 1'b0;
            end
        end
    end

    // CPU control and status follow the state directly; the CPU leaves
    // reset at RUN and stays out of it so RF and DM survive for the dump.
    assign cpu_rst_n = (state == ST_RUN) || (state == ST_DUMP_RF) ||
                       (state == ST_DUMP_DM) || (state == ST_DONE);
    assign cpu_stall = (state != ST_RUN);
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_sel   = mem_sel_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_re    = mem_re_c;
    assign bus.rf_raddr  = rf_raddr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;

endmodule

// File: tb/tb_mem_load_dump_ctrl.sv
// Directed bench for mem_load_dump_ctrl with 8-byte memories, 4 GPRs and a
// 100-cycle run limit. Inputs change on the falling edge; outputs are
// sampled 1 time unit later.
module tb_mem_load_dump_ctrl;
    import mem_load_dump_ctrl_pkg::*;

    localparam int IMEM     = 8;
    localparam int DMEM     = 8;
    localparam int GPR      = 4;
    localparam int XLEN     = 32;
    localparam int RUNC     = 100;
    localparam int AW       = calc_aw(IMEM, DMEM);
    localparam int RW       = calc_rw(GPR);
    localparam int DUMP_LEN = GPR * XLEN / 8 + DMEM;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   start = 1'b0;
    logic   cpu_halt = 1'b0;
    logic   cpu_rst_n, cpu_stall, busy, done, timed_out;
    state_t dbg_state;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]      im_mem [IMEM];
    logic [7:0]      dm_mem [DMEM];
    logic [XLEN-1:0] rf_model [GPR];
    logic [7:0]      got [32];
    logic [7:0]      exp_q [$];

    mem_load_dump_ctrl_if #(.AW(AW), .RW(RW), .XLEN(XLEN)) bus ();

    mem_load_dump_ctrl #(
        .IMEM_BYTES (IMEM),
        .DMEM_BYTES (DMEM),
        .GPR_SIZE   (GPR),
        .XLEN       (XLEN),
        .RUN_CYCLES (RUNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cpu_halt  (cpu_halt),
        .cpu_rst_n (cpu_rst_n),
        .cpu_stall (cpu_stall),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // CPU memories: byte writes, data-memory read with one cycle latency.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_rdata <= 8'h00;
        end else begin
            if (bus.mem_we) begin
                if (bus.mem_sel) dm_mem[bus.mem_addr] <= bus.mem_wdata;
                else             im_mem[bus.mem_addr] <= bus.mem_wdata;
            end
            if (bus.mem_re) bus.mem_rdata <= dm_mem[bus.mem_addr];
        end
    end

    assign bus.rf_rdata = rf_model[bus.rf_raddr];

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish before 400000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"},     32'(dbg_state),     32'(ST_IDLE));
        check({tag, "_in_ready"},  32'(bus.in_ready),  0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    0);
        check({tag, "_mem_re"},    32'(bus.mem_re),    0);
        check({tag, "_busy"},      32'(busy),          0);
        check({tag, "_done"},      32'(done),          0);
        check({tag, "_timed_out"}, 32'(timed_out),     0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n),     0);
        check({tag, "_cpu_stall"}, 32'(cpu_stall),     1);
        check({tag, "_data_addr"},
              32'({bus.mem_addr, bus.mem_wdata, bus.out_data, bus.rf_raddr}), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] base, input bit gaps);
        int accepted = 0;
        int offered  = 0;
        int we_cyc   = 0;
        int iters    = 0;
        while (accepted < IMEM + DMEM && iters < 300) begin
            @(negedge clk);
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_data  = base + 8'(accepted);
            #1;
            if (iters == 0) begin
                check("load_first_state", 32'(dbg_state), 32'(ST_LOAD_IM));
                check("load_tmo_cleared", 32'(timed_out), 0);
                check("load_cpu_held",    32'({cpu_rst_n, cpu_stall, busy}), 32'b011);
            end
            if (bus.in_valid) offered++;
            if (bus.mem_we) we_cyc++;
            if (bus.in_valid && bus.in_ready) accepted++;
            iters++;
        end
        check("load_accepted", accepted, IMEM + DMEM);
        check("load_we_cycles", we_cyc, offered);
        if (!gaps) check("load_cycles", iters, 16);
    endtask

    task automatic do_run(input int halt_at, input int start_at,
                          input int exp_len, input int exp_tmo);
        int k = 0;
        int stall_low = 0;
        int leak = 0;
        while (k < 300) begin
            @(negedge clk);
            if (dbg_state != ST_RUN) break;
            cpu_halt     = (k == halt_at);
            start        = (k == start_at);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
            #1;
            if (!cpu_stall) stall_low++;
            if (bus.in_ready || bus.mem_we) leak++;
            k++;
        end
        cpu_halt = 1'b0;
        start    = 1'b0;
        check("run_len",        k, exp_len);
        check("run_stall_low",  stall_low, exp_len);
        check("run_timed_out",  32'(timed_out), 32'(exp_tmo));
        check("run_in_blocked", leak, 0);
        check("run_exit_state", 32'(dbg_state), 32'(ST_DUMP_RF));
        check("run_cpu_rst_n",  32'(cpu_rst_n), 1);
    endtask

    task automatic build_exp(input logic [7:0] base);
        exp_q.delete();
        for (int i = 0; i < GPR; i++)
            for (int b = 0; b < XLEN / 8; b++)
                exp_q.push_back(rf_model[i][8*b +: 8]);
        for (int k = 0; k < DMEM; k++)
            exp_q.push_back(base + 8'(IMEM + k));
    endtask

    task automatic do_dump(input bit rand_ready, input int abort_after, input int exp_done_it);
        int n = 0;
        int it = 0;
        int last_it = -1;
        int done_it = -1;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (it < 500) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (done) begin
                done_it = it;
                break;
            end
            if (stalled) begin
                check("dump_hold_valid", 32'(bus.out_valid), 1);
                check("dump_hold_data",  32'(bus.out_data), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (n < 32) got[n] = bus.out_data;
                if (exp_q.size() == 0) check("dump_extra_byte", n + 1, DUMP_LEN);
                else check($sformatf("dump_byte%0d", n), 32'(bus.out_data), 32'(exp_q.pop_front()));
                n++;
                last_it = it;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (n == abort_after) break;
            it++;
            @(negedge clk);
        end
        if (abort_after < 0) begin
            check("dump_count",        n, DUMP_LEN);
            check("dump_done_latency", done_it, last_it + 1);
            check("dump_done_status",  32'({done, busy, bus.out_valid}), 32'b100);
            if (exp_done_it >= 0) check("dump_done_cycle", done_it, exp_done_it);
        end
    endtask

    task automatic check_mem(input logic [7:0] base);
        for (int i = 0; i < IMEM; i++)
            check($sformatf("im_%0d", i), 32'(im_mem[i]), 32'(base + 8'(i)));
        for (int i = 0; i < DMEM; i++)
            check($sformatf("dm_%0d", i), 32'(dm_mem[i]), 32'(base + 8'(IMEM + i)));
    endtask

    initial begin
        rf_model[0] = 32'h0000_0000;
        rf_model[1] = 32'hDEAD_BEEF;
        rf_model[2] = 32'h1234_5678;
        rf_model[3] = 32'hA5C3_0F81;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h5A;
        bus.out_ready = 1'b1;

        // reset values, with a host byte offered that must not be taken
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("idle");

        // A: back-to-back load, no halt -> forced stop, ready always high
        pulse_start();
        do_load(8'h00, 1'b0);
        do_run(-1, -1, 100, 1);
        build_exp(8'h00);
        do_dump(1'b0, -1, 32);
        check_mem(8'h00);
        check("x1_byte0", 32'(got[4]), 32'h EF);
        check("x1_byte1", 32'(got[5]), 32'h BE);
        check("x1_byte2", 32'(got[6]), 32'h AD);
        check("x1_byte3", 32'(got[7]), 32'h DE);
        check("a_dm_first", 32'(got[16]), 32'h08);

        // B: restart from DONE, gappy load, halt at run cycle 5 with a
        // stray start mid-run, randomly stalled dump
        pulse_start();
        do_load(8'h40, 1'b1);
        do_run(5, 3, 6, 0);
        build_exp(8'h40);
        do_dump(1'b1, -1, -1);
        check_mem(8'h40);

        // C: halt together with the run limit, then reset mid data dump
        pulse_start();
        do_load(8'h80, 1'b0);
        do_run(99, -1, 100, 0);
        build_exp(8'h80);
        do_dump(1'b0, 18, -1);
        check("c_abort_state", 32'(dbg_state), 32'(ST_DUMP_DM));
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // D: fresh session after the abort
        rf_model[2] = 32'h0BAD_F00D;
        pulse_start();
        do_load(8'hC0, 1'b1);
        do_run(2, -1, 3, 0);
        build_exp(8'hC0);
        do_dump(1'b1, -1, -1);
        check_mem(8'hC0);
        check("d_x2_byte0", 32'(got[8]), 32'h0D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
